// File: rtl/bmem_pkg.sv
// Shared widths and FSM state type for the bmem burst responder.
package bmem_pkg;

    localparam int unsigned BEAT_BITS        = 64;
    localparam int unsigned LINE_BITS        = 256;
    localparam int unsigned BEATS            = 4;
    localparam int unsigned LINE_OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_BURST
    } bmem_state_t;

endpackage

// File: rtl/bmem_line_array.sv
// Line storage with a beat-granular write port and a registered beat read port.
module bmem_line_array
    import bmem_pkg::*;
#(
    parameter  int unsigned DEPTH_LINES = 64,
    localparam int unsigned IDX_BITS    = $clog2(DEPTH_LINES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IDX_BITS-1:0]  widx,
    input  logic [1:0]           wbeat,
    input  logic [BEAT_BITS-1:0] wdata,
    input  logic                 we,
    input  logic [IDX_BITS-1:0]  ridx,
    input  logic [1:0]           rbeat,
    input  logic                 re,
    output logic [BEAT_BITS-1:0] rdata
);

    localparam int unsigned WORDS = DEPTH_LINES * (LINE_BITS / BEAT_BITS);

    // Each line is held as four consecutive beat words so the RAM infers cleanly.
    logic [BEAT_BITS-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[{widx, wbeat}] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[{ridx, rbeat}];
        end
    end

endmodule

// File: rtl/bmem_burst_responder.sv
// bmem burst target: 4-beat line reads after a fixed latency, 4-beat line writes.
module bmem_burst_responder
    import bmem_pkg::*;
#(
    parameter int unsigned DEPTH_LINES  = 64,
    parameter int unsigned READ_LATENCY = 4,
    parameter int unsigned BEATS        = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] bmem_addr,
    input  logic        bmem_read,
    input  logic        bmem_write,
    input  logic [63:0] bmem_wdata,
    output logic        bmem_ready,
    output logic [63:0] bmem_rdata,
    output logic        bmem_rvalid,
    output logic        proto_err
);

    localparam int unsigned IDX_BITS = $clog2(DEPTH_LINES);
    localparam int unsigned LAT_BITS = $clog2(READ_LATENCY) + 1;

    bmem_state_t         state_q, state_d;
    logic [IDX_BITS-1:0] idx_q, idx_d, addr_idx, widx;
    logic [1:0]          beat_q, beat_d, wbeat;
    logic [LAT_BITS-1:0] lat_q, lat_d;
    logic                ready_q, rvalid_q, err_q, err_d;
    logic                we, re;
    logic                unused_addr;

    assign addr_idx    = bmem_addr[LINE_OFFSET_BITS +: IDX_BITS];
    assign unused_addr = ^{bmem_addr[31:LINE_OFFSET_BITS+IDX_BITS], bmem_addr[LINE_OFFSET_BITS-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            beat_q   <= '0;
            lat_q    <= '0;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            beat_q   <= beat_d;
            lat_q    <= lat_d;
            ready_q  <= (state_d == IDLE) || (state_d == WR_BURST);
            // The array read is registered, so rvalid trails the RD_BURST state by one cycle.
            rvalid_q <= (state_q == RD_BURST);
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        err_d   = err_q;
        we      = 1'b0;
        re      = 1'b0;
        widx    = idx_q;
        wbeat   = beat_q;
        case (state_q)
            IDLE: begin
                if (ready_q && bmem_read) begin
                    idx_d  = addr_idx;
                    beat_d = '0;
                    if (bmem_write) begin
                        err_d = 1'b1;
                    end
                    if (READ_LATENCY == 1) begin
                        state_d = RD_BURST;
                    end else begin
                        state_d = RD_WAIT;
                        lat_d   = LAT_BITS'(READ_LATENCY - 1);
                    end
                end else if (ready_q && bmem_write) begin
                    we      = 1'b1;
                    widx    = addr_idx;
                    wbeat   = '0;
                    idx_d   = addr_idx;
                    beat_d  = 2'd1;
                    state_d = WR_BURST;
                end
            end
            RD_WAIT: begin
                if (bmem_read || bmem_write) begin
                    err_d = 1'b1;
                end
                lat_d = lat_q - LAT_BITS'(1);
                if (lat_d == '0) begin
                    state_d = RD_BURST;
                    beat_d  = '0;
                end
            end
            RD_BURST: begin
                if (bmem_read || bmem_write) begin
                    err_d = 1'b1;
                end
                re     = 1'b1;
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'(BEATS - 1)) begin
                    state_d = IDLE;
                end
            end
            WR_BURST: begin
                if (bmem_read) begin
                    err_d = 1'b1;
                end
                if (bmem_write) begin
                    we     = 1'b1;
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'(BEATS - 1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    bmem_line_array #(
        .DEPTH_LINES(DEPTH_LINES)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .widx  (widx),
        .wbeat (wbeat),
        .wdata (bmem_wdata),
        .we    (we),
        .ridx  (idx_q),
        .rbeat (beat_q),
        .re    (re),
        .rdata (bmem_rdata)
    );

    assign bmem_ready  = ready_q;
    assign bmem_rvalid = rvalid_q;
    assign proto_err   = err_q;

endmodule

// File: tb/tb_bmem_burst_responder.sv
// Self-checking bench for bmem_burst_responder: directed sequences, vector table, random traffic.
module tb_bmem_burst_responder;

    localparam int unsigned LAT = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_write;
    logic [63:0] bmem_wdata;
    logic        bmem_ready;
    logic [63:0] bmem_rdata;
    logic        bmem_rvalid;
    logic        proto_err;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: one 256-bit entry per line index, plus which lines hold known data.
    logic [255:0] ref_line [64];
    int unsigned  valid_q [$];

    typedef struct {
        logic [31:0]  wr_addr;
        logic [31:0]  rd_addr;
        logic [255:0] line;
    } vec_t;

    vec_t vecs [4];

    bmem_burst_responder #(
        .DEPTH_LINES  (64),
        .READ_LATENCY (LAT),
        .BEATS        (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid),
        .proto_err   (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int unsigned line_of(input logic [31:0] addr);
        return (addr >> 5) % 64;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom();
        return l;
    endfunction

    task automatic wait_ready(input string tag);
        int unsigned n = 0;
        while (!bmem_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 64'(bmem_ready), 64'd1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                            input int bub_after, input int nbub, input string tag);
        logic [31:0] junk;
        int unsigned idx;
        wait_ready(tag);
        for (int b = 0; b < 4; b++) begin
            junk       = $urandom();
            bmem_write = 1'b1;
            bmem_addr  = (b == 0) ? addr : junk;
            bmem_wdata = line[64*b +: 64];
            tick();
            bmem_write = 1'b0;
            if (b == bub_after) repeat (nbub) tick();
        end
        idx = line_of(addr);
        if (!(idx inside {valid_q})) valid_q.push_back(idx);
        ref_line[idx] = line;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [255:0] exp,
                           input bit with_write, input string tag);
        int unsigned lat = 0;
        wait_ready(tag);
        bmem_read  = 1'b1;
        bmem_write = with_write;
        bmem_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
        bmem_addr  = addr;
        tick();
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        while (!bmem_rvalid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(LAT));
        for (int b = 0; b < 4; b++) begin
            check($sformatf("%s_rvalid%0d", tag, b), 64'(bmem_rvalid), 64'd1);
            check($sformatf("%s_beat%0d", tag, b), bmem_rdata, exp[64*b +: 64]);
            tick();
        end
        check({tag, "_rvalid_end"}, 64'(bmem_rvalid), 64'd0);
    endtask

    logic [255:0] line_a;
    logic [255:0] line_b;
    logic [31:0]  raddr;
    int unsigned  ridx;
    int unsigned  lat;

    initial begin
        line_a = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
        line_b = {64'hB3B3_0000_0000_0003, 64'hB2B2_0000_0000_0002,
                  64'hB1B1_0000_0000_0001, 64'hB0B0_0000_0000_0000};
        vecs[0] = '{wr_addr: 32'h0000_0800, rd_addr: 32'h0000_0000, line: line_b};
        vecs[1] = '{wr_addr: 32'h0000_0040, rd_addr: 32'h0000_004C, line: line_a};
        vecs[2] = '{wr_addr: 32'hFFFF_FFE0, rd_addr: 32'h0000_07E0,
                    line: {4{64'h0123_4567_89AB_CDEF}}};
        vecs[3] = '{wr_addr: 32'h0000_0020, rd_addr: 32'h1234_503F,
                    line: {64'h4, 64'h3, 64'h2, 64'h1}};

        rst_n      = 1'b0;
        bmem_addr  = '0;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_wdata = '0;

        // Reset behaviour and ready rising on the first edge after release.
        #12;
        check("rst_ready", 64'(bmem_ready), 64'd0);
        check("rst_rvalid", 64'(bmem_rvalid), 64'd0);
        check("rst_err", 64'(proto_err), 64'd0);
        check("rst_rdata", bmem_rdata, 64'd0);
        #1 rst_n = 1'b1;
        #1 check("rel_ready_pre", 64'(bmem_ready), 64'd0);
        tick();
        check("rel_ready_post", 64'(bmem_ready), 64'd1);

        // Write with two bubbles after beat 1, then read back.
        do_write(32'h0000_0040, line_a, 1, 2, "wr40");
        do_read(32'h0000_0040, line_a, 1'b0, "rd40");

        // Read issued the cycle after the final write beat.
        do_write(32'h0000_0060, line_b, -1, 0, "wr60");
        do_read(32'h0000_0060, line_b, 1'b0, "raw60");
        check("raw_err", 64'(proto_err), 64'd0);

        // Vector table: aliasing and ignored offset bits.
        for (int i = 0; i < 4; i++) begin
            do_write(vecs[i].wr_addr, vecs[i].line, -1, 0, $sformatf("vw%0d", i));
            do_read(vecs[i].rd_addr, vecs[i].line, 1'b0, $sformatf("vr%0d", i));
        end

        // Read and write together: read wins, no array write, sticky error.
        do_read(32'h0000_0040, ref_line[2], 1'b1, "rdwr");
        check("rdwr_err", 64'(proto_err), 64'd1);
        do_read(32'h0000_0040, ref_line[2], 1'b0, "rdwr_after");
        check("rdwr_err_sticky", 64'(proto_err), 64'd1);

        // Reset asserted mid-burst after beat 1.
        wait_ready("rstmid");
        bmem_read = 1'b1;
        bmem_addr = 32'h0000_0040;
        tick();
        bmem_read = 1'b0;
        lat = 0;
        while (!bmem_rvalid && lat < 20) begin
            tick();
            lat++;
        end
        check("rstmid_latency", 64'(lat), 64'(LAT));
        check("rstmid_beat0", bmem_rdata, ref_line[2][63:0]);
        tick();
        check("rstmid_beat1", bmem_rdata, ref_line[2][127:64]);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_rvalid", 64'(bmem_rvalid), 64'd0);
        check("rstmid_ready", 64'(bmem_ready), 64'd0);
        check("rstmid_err", 64'(proto_err), 64'd0);
        #2 rst_n = 1'b1;
        tick();
        check("rstmid_ready_rel", 64'(bmem_ready), 64'd1);
        do_read(32'h0000_0040, ref_line[2], 1'b0, "rstmid_rd");

        // Random traffic against the line model.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                raddr = $urandom();
                do_write(raddr, rand_line(), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 2)), $sformatf("rw%0d", n));
            end else begin
                ridx  = valid_q[$urandom_range(0, valid_q.size() - 1)];
                raddr = $urandom();
                raddr = (raddr & 32'hFFFF_F81F) | (ridx << 5);
                do_read(raddr, ref_line[ridx], 1'b0, $sformatf("rr%0d", n));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
